// File: rtl/dk_video_retimer.sv
// ============================================================================
// Module      : dk_video_retimer
// Description : Re-times a core's video stream onto a one-cycle pixel enable
//               derived from the core's pixel-clock level. Delays hblank by a
//               programmable number of pixels, blanks colour, measures the
//               active raster and flags stable timing. A watchdog forces a
//               blanked, unlocked state when the pixel clock stops.
// Ports       : clk_sys        - system clock, all logic on its rising edge
//               reset          - synchronous active-high reset
//               pix_clk_in     - core pixel clock level (clk_sys domain)
//               hblank_in/vblank_in, hs_n_in/vs_n_in, r_in/g_in/b_in
//                              - core blanking, syncs (active-low), colour
//               ce_pix         - one-cycle pixel enable
//               rgb_out        - blanked {r,g,b}
//               hblank/vblank/hsync/vsync - aligned, active-high
//               active_width/active_height - last measured active raster
//               timing_valid   - two consecutive identical frames seen
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dk_video_retimer #(
    parameter int HBL_DELAY = 9,
    parameter int WD_CYCLES = 1024
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        pix_clk_in,
    input  logic        hblank_in,
    input  logic        vblank_in,
    input  logic        hs_n_in,
    input  logic        vs_n_in,
    input  logic [3:0]  r_in,
    input  logic [3:0]  g_in,
    input  logic [3:0]  b_in,
    output logic        ce_pix,
    output logic [11:0] rgb_out,
    output logic        hblank,
    output logic        vblank,
    output logic        hsync,
    output logic        vsync,
    output logic [8:0]  active_width,
    output logic [8:0]  active_height,
    output logic        timing_valid
);

    localparam int         WD_W   = $clog2(WD_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_CYCLES);
    localparam logic [8:0] CNT_MAX = 9'd511;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOCK1  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic                 old_pix_q, old_pix_d;
    logic                 ce_q, ce_d;
    logic [HBL_DELAY-1:0] line_q, line_d;
    logic                 hblank_q, hblank_d;
    logic                 vblank_q, vblank_d;
    logic                 hsync_q, hsync_d;
    logic                 vsync_q, vsync_d;
    logic [11:0]          rgb_q, rgb_d;
    logic [8:0]           wcnt_q, wcnt_d;
    logic [8:0]           lcnt_q, lcnt_d;
    logic [8:0]           lwidth_q, lwidth_d;
    logic [8:0]           aw_q, aw_d;
    logic [8:0]           ah_q, ah_d;
    logic [1:0]           state_q, state_d;
    logic [WD_W-1:0]      wd_q, wd_d;

    logic                 pix_edge;
    logic                 hbl_new;
    logic                 vbl_new;

    assign pix_edge = pix_clk_in & ~old_pix_q;

    always_comb begin
        old_pix_d = pix_clk_in;
        ce_d      = pix_edge;
        line_d    = line_q;
        hblank_d  = hblank_q;
        vblank_d  = vblank_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        rgb_d     = rgb_q;
        wcnt_d    = wcnt_q;
        lcnt_d    = lcnt_q;
        lwidth_d  = lwidth_q;
        aw_d      = aw_q;
        ah_d      = ah_q;
        state_d   = state_q;
        hbl_new   = 1'b1;
        vbl_new   = 1'b1;

        if (pix_edge) begin
            wd_d = '0;
        end else if (wd_q == WD_MAX) begin
            wd_d = wd_q;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end

        if (pix_edge) begin
            // The outputs take the post-shift value so they change together
            // with the ce_pix pulse that follows this cycle.
            line_d   = (line_q << 1) | HBL_DELAY'(hblank_in);
            hbl_new  = line_d[HBL_DELAY-1];
            vbl_new  = vblank_in;
            hblank_d = hbl_new;
            vblank_d = vbl_new;
            hsync_d  = ~hs_n_in;
            vsync_d  = ~vs_n_in;
            rgb_d    = (!hbl_new && !vbl_new) ? {r_in, g_in, b_in} : 12'h000;

            if (!hbl_new && !vbl_new && wcnt_q != CNT_MAX) begin
                wcnt_d = wcnt_q + 9'd1;
            end

            if (hbl_new && !hblank_q) begin
                if (wcnt_q != 9'd0) begin
                    lwidth_d = wcnt_q;
                    if (!vbl_new && lcnt_q != CNT_MAX) begin
                        lcnt_d = lcnt_q + 9'd1;
                    end
                end
                wcnt_d = 9'd0;
            end

            // Uses the *_d values so a width latched on this same ce is the
            // one reported when hblank and vblank rise together.
            if (vbl_new && !vblank_q) begin
                aw_d   = lwidth_d;
                ah_d   = lcnt_d;
                lcnt_d = 9'd0;
                if (lwidth_d == 9'd0 || ah_d == 9'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    case (state_q)
                        ST_IDLE:   state_d = ST_LOCK1;
                        ST_LOCK1:  state_d = (lwidth_d == aw_q && ah_d == ah_q) ? ST_LOCKED : ST_LOCK1;
                        ST_LOCKED: state_d = (lwidth_d == aw_q && ah_d == ah_q) ? ST_LOCKED : ST_LOCK1;
                        default:   state_d = ST_IDLE;
                    endcase
                end
            end
        end else if (wd_q == WD_MAX) begin
            // Pixel clock has stopped: present a blanked, unlocked raster.
            // The delay line is left untouched so restart is seamless.
            state_d  = ST_IDLE;
            hblank_d = 1'b1;
            vblank_d = 1'b1;
            rgb_d    = 12'h000;
            hsync_d  = 1'b0;
            vsync_d  = 1'b0;
            wcnt_d   = 9'd0;
            lcnt_d   = 9'd0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            old_pix_q <= 1'b0;
            ce_q      <= 1'b0;
            line_q    <= '1;
            hblank_q  <= 1'b1;
            vblank_q  <= 1'b1;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            rgb_q     <= 12'h000;
            wcnt_q    <= 9'd0;
            lcnt_q    <= 9'd0;
            lwidth_q  <= 9'd0;
            aw_q      <= 9'd0;
            ah_q      <= 9'd0;
            state_q   <= ST_IDLE;
            wd_q      <= '0;
        end else begin
            old_pix_q <= old_pix_d;
            ce_q      <= ce_d;
            line_q    <= line_d;
            hblank_q  <= hblank_d;
            vblank_q  <= vblank_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            rgb_q     <= rgb_d;
            wcnt_q    <= wcnt_d;
            lcnt_q    <= lcnt_d;
            lwidth_q  <= lwidth_d;
            aw_q      <= aw_d;
            ah_q      <= ah_d;
            state_q   <= state_d;
            wd_q      <= wd_d;
        end
    end

    assign ce_pix        = ce_q;
    assign rgb_out       = rgb_q;
    assign hblank        = hblank_q;
    assign vblank        = vblank_q;
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;
    assign active_width  = aw_q;
    assign active_height = ah_q;
    assign timing_valid  = (state_q == ST_LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_dk_video_retimer.sv
// ============================================================================
// Module      : tb_dk_video_retimer
// Description : Self-checking bench for dk_video_retimer. Every pixel edge
//               pushes its expected aligned outputs to a queue; each ce_pix
//               pops and compares. Raster measurements and lock status are
//               checked against constants after each frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dk_video_retimer;

    localparam int HBL = 9;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        pix_clk_in;
    logic        hblank_in, vblank_in, hs_n_in, vs_n_in;
    logic [3:0]  r_in, g_in, b_in;
    logic        ce_pix;
    logic [11:0] rgb_out;
    logic        hblank, vblank, hsync, vsync;
    logic [8:0]  active_width, active_height;
    logic        timing_valid;

    always #5 clk_sys = ~clk_sys;

    dk_video_retimer #(.HBL_DELAY(HBL), .WD_CYCLES(1024)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .pix_clk_in   (pix_clk_in),
        .hblank_in    (hblank_in),
        .vblank_in    (vblank_in),
        .hs_n_in      (hs_n_in),
        .vs_n_in      (vs_n_in),
        .r_in         (r_in),
        .g_in         (g_in),
        .b_in         (b_in),
        .ce_pix       (ce_pix),
        .rgb_out      (rgb_out),
        .hblank       (hblank),
        .vblank       (vblank),
        .hsync        (hsync),
        .vsync        (vsync),
        .active_width (active_width),
        .active_height(active_height),
        .timing_valid (timing_valid)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [11:0] rgb;
        logic        hb;
        logic        vb;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t           sb_q[$];
    exp_t           mon_e;
    logic [HBL-1:0] m_line;

    task automatic model_reset();
        m_line = '1;
    endtask

    always @(negedge clk_sys) begin
        if (ce_pix === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("ce_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rgb_out", 32'(rgb_out), 32'(mon_e.rgb));
                chk("hblank",  32'(hblank),  32'(mon_e.hb));
                chk("vblank",  32'(vblank),  32'(mon_e.vb));
                chk("hsync",   32'(hsync),   32'(mon_e.hs));
                chk("vsync",   32'(vsync),   32'(mon_e.vs));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // One pixel: pix_clk_in high for hi cycles then low for lo cycles.
    task automatic pix_edge(input logic hb, input logic vb, input logic hsn, input logic vsn,
                            input logic [11:0] col, input int hi, input int lo);
        exp_t e;
        int   n_ce;
        hblank_in  = hb;
        vblank_in  = vb;
        hs_n_in    = hsn;
        vs_n_in    = vsn;
        {r_in, g_in, b_in} = col;
        pix_clk_in = 1'b1;
        m_line = {m_line[HBL-2:0], hb};
        e.hb  = m_line[HBL-1];
        e.vb  = vb;
        e.hs  = ~hsn;
        e.vs  = ~vsn;
        e.rgb = (!e.hb && !vb) ? col : 12'h000;
        sb_q.push_back(e);
        n_ce = 0;
        for (int i = 0; i < hi + lo; i++) begin
            @(posedge clk_sys);
            #1;
            if (ce_pix) n_ce++;
            if (i == 0) chk("ce_latency", 32'(ce_pix), 32'd1);
            if (i == hi - 1) pix_clk_in = 1'b0;
        end
        chk("ce_per_pixel", 32'(n_ce), 32'd1);
    endtask

    int g_hi = 1;
    int g_lo = 1;

    task automatic send_line(input int vis, input int blank, input logic vb_all,
                             input int vb_from, input int ln, input int start);
        logic hb, vb, hsn;
        for (int i = start; i < vis + blank; i++) begin
            hb  = (i >= vis);
            vb  = vb_all || (i >= vb_from);
            hsn = !(i >= vis + 2 && i < vis + 6);
            pix_edge(hb, vb, hsn, !vb_all, {4'(i), 4'(ln), 4'hA}, g_hi, g_lo);
        end
    endtask

    task automatic send_vbl();
        send_line(20, 12, 1'b1, 0, 0, 0);
        send_line(20, 12, 1'b1, 0, 1, 0);
    endtask

    task automatic send_frame(input int vis, input int lines);
        for (int l = 0; l < lines; l++) send_line(vis, 12, 1'b0, 1 << 30, l, 0);
        send_vbl();
    endtask

    task automatic chk_reset_state();
        chk("rst_ce",     32'(ce_pix),        32'd0);
        chk("rst_rgb",    32'(rgb_out),       32'd0);
        chk("rst_hblank", 32'(hblank),        32'd1);
        chk("rst_vblank", 32'(vblank),        32'd1);
        chk("rst_hsync",  32'(hsync),         32'd0);
        chk("rst_vsync",  32'(vsync),         32'd0);
        chk("rst_aw",     32'(active_width),  32'd0);
        chk("rst_ah",     32'(active_height), 32'd0);
        chk("rst_valid",  32'(timing_valid),  32'd0);
    endtask

    initial begin
        reset = 1'b1; pix_clk_in = 1'b0;
        hblank_in = 1'b1; vblank_in = 1'b1; hs_n_in = 1'b1; vs_n_in = 1'b1;
        r_in = 4'h0; g_in = 4'h0; b_in = 4'h0;
        model_reset();
        idle(3);
        chk_reset_state();
        reset = 1'b0;
        idle(2);

        // Frame 1 at an 8-cycle pixel period, then faster frames.
        g_hi = 4; g_lo = 4;
        send_frame(20, 6);
        chk("f1_aw", 32'(active_width), 32'd20);
        chk("f1_ah", 32'(active_height), 32'd6);
        chk("f1_valid", 32'(timing_valid), 32'd0);
        g_hi = 1; g_lo = 1;
        send_frame(20, 6);
        chk("f2_aw", 32'(active_width), 32'd20);
        chk("f2_ah", 32'(active_height), 32'd6);
        chk("f2_valid", 32'(timing_valid), 32'd1);
        send_frame(19, 6);
        chk("f3_aw", 32'(active_width), 32'd19);
        chk("f3_valid", 32'(timing_valid), 32'd0);
        send_frame(19, 6);
        chk("f4_valid", 32'(timing_valid), 32'd1);

        // Stop the pixel clock mid-line while locked.
        send_line(19, 12, 1'b0, 1 << 30, 0, 0);
        send_line(19, 12, 1'b0, 1 << 30, 1, 0);
        for (int i = 0; i < 10; i++)
            pix_edge(1'b0, 1'b0, 1'b1, 1'b1, {4'(i), 4'd2, 4'hA}, 1, 1);
        idle(1000);
        chk("wd_pre_hblank", 32'(hblank), 32'd0);
        chk("wd_pre_valid", 32'(timing_valid), 32'd1);
        idle(30);
        chk("wd_valid",  32'(timing_valid), 32'd0);
        chk("wd_hblank", 32'(hblank), 32'd1);
        chk("wd_vblank", 32'(vblank), 32'd1);
        chk("wd_rgb",    32'(rgb_out), 32'd0);
        chk("wd_hsync",  32'(hsync), 32'd0);
        chk("wd_vsync",  32'(vsync), 32'd0);
        send_line(19, 12, 1'b0, 1 << 30, 2, 10);
        for (int l = 3; l < 6; l++) send_line(19, 12, 1'b0, 1 << 30, l, 0);
        send_vbl();
        chk("wd_part_ah", 32'(active_height), 32'd4);
        chk("wd_part_valid", 32'(timing_valid), 32'd0);
        send_frame(19, 6);
        chk("relock1_valid", 32'(timing_valid), 32'd0);
        send_frame(19, 6);
        chk("relock2_valid", 32'(timing_valid), 32'd1);

        // Reset pulse mid-line of a locked frame.
        for (int l = 0; l < 3; l++) send_line(20, 12, 1'b0, 1 << 30, l, 0);
        for (int i = 0; i < 10; i++)
            pix_edge(1'b0, 1'b0, 1'b1, 1'b1, {4'(i), 4'd3, 4'hA}, 1, 1);
        reset = 1'b1;
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        model_reset();
        chk_reset_state();
        send_line(20, 12, 1'b0, 1 << 30, 3, 10);
        send_line(20, 12, 1'b0, 1 << 30, 4, 0);
        send_line(20, 12, 1'b0, 1 << 30, 5, 0);
        send_vbl();
        chk("post_rst_ah", 32'(active_height), 32'd3);
        chk("post_rst_aw", 32'(active_width), 32'd20);
        chk("post_rst_valid", 32'(timing_valid), 32'd0);

        // hblank and vblank rise on the same ce: width of that line is reported.
        for (int l = 0; l < 5; l++) send_line(20, 12, 1'b0, 1 << 30, l, 0);
        send_line(17, 12, 1'b0, 17 + HBL - 1, 5, 0);
        send_vbl();
        chk("simul_aw", 32'(active_width), 32'd17);

        // Over-long line saturates the width measurement.
        send_line(600, 12, 1'b0, 1 << 30, 0, 0);
        send_vbl();
        chk("sat_aw", 32'(active_width), 32'd511);
        chk("sat_ah", 32'(active_height), 32'd1);

        idle(4);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
